mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/alu_pkg.sv | 23 ++
 rtl/mult_datapath.sv | 52 +++++
 rtl/mult_unit.sv | 106 ++++++++++
 tb/tb_mult_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Funct codes shared by the ALU and the multiplier, plus the multiplier FSM encoding.
package alu_pkg;

  localparam logic [5:0] FUNCT_ADD   = 6'd32;
  localparam logic [5:0] FUNCT_SUB   = 6'd34;
  localparam logic [5:0] FUNCT_AND   = 6'd36;
  localparam logic [5:0] FUNCT_OR    = 6'd37;
  localparam logic [5:0] FUNCT_SLT   = 6'd42;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  function automatic logic is_mult_start(input logic start, input logic [5:0] funct);
    return start && (funct == FUNCT_MULTU);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: one conditional add of the shifted multiplicand per step.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_next_o,
  output logic               mpr_rest_zero_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mpr_q, mpr_d;
  logic [2*WIDTH-1:0] addend;

  assign addend      = mpr_q[0] ? mcand_q : '0;
  assign prod_next_o = prod_q + addend;
  // True when the multiplier will be zero once this step shifts it.
  assign mpr_rest_zero_o = (mpr_q[WIDTH-1:1] == '0);

  always_comb begin
    mcand_d = mcand_q;
    mpr_d   = mpr_q;
    prod_d  = prod_q;
    if (load_i) begin
      mcand_d = {{WIDTH{1'b0}}, a_i};
      mpr_d   = b_i;
      prod_d  = '0;
    end else if (step_i) begin
      prod_d  = prod_next_o;
      mcand_d = mcand_q << 1;
      mpr_d   = mpr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_q <= '0;
      mpr_q   <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      mpr_q   <= mpr_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Sequential unsigned multiplier with HI/LO result registers and MFHI/MFLO read mux.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mult_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               accept;
  logic               step;
  logic               last_iter;
  logic [2*WIDTH-1:0] prod_next;
  logic               mpr_rest_zero;

  assign accept    = (state_q == IDLE) && is_mult_start(start, Signal);
  assign step      = (state_q == RUN);
  assign last_iter = (cnt_q == CW'(WIDTH - 1)) || (EarlyExit && mpr_rest_zero);

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk             (clk),
    .rst_n_i         (reset),
    .load_i          (accept),
    .step_i          (step),
    .a_i             (dataA),
    .b_i             (dataB),
    .prod_next_o     (prod_next),
    .mpr_rest_zero_o (mpr_rest_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // HI/LO only change here, so reads during RUN see the previous result.
        if (last_iter) begin
          hi_d    = prod_next[2*WIDTH-1:WIDTH];
          lo_d    = prod_next[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_comb begin
    dataOut = '0;
    case (Signal)
      FUNCT_MFHI: dataOut = hi_q;
      FUNCT_MFLO: dataOut = lo_q;
      default:    dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: issued multiplies queue their expected LO and done cycle.
module tb_mult_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_ADD   = 6'd32;

`ifdef MULT_EARLY_EXIT_EN
  localparam int INJ = 2;
`else
  localparam int INJ = 5;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dataA, dataB;
  logic [5:0]   Signal;
  logic         start;
  logic         busy, done;
  logic [W-1:0] dataOut;

  typedef struct {
    logic [W-1:0] lo;
    int           due;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   id_ctr = 0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
`else
    return W + 0 * int'(b[0]);
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding multiply.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.due));
        check($sformatf("op%0d_lo_at_done", e.id), {32'b0, dataOut}, {32'b0, e.lo});
        $display("[TB] op%0d done at cycle %0d, LO=%h", e.id, cyc, dataOut);
      end
    end
  end

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lo_exp, input bit expect_done);
    dataA  = a;
    dataB  = b;
    Signal = F_MULTU;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    Signal = F_MFLO;
    dataA  = ~a;
    dataB  = ~b;
    if (expect_done) sb.push_back('{lo: lo_exp, due: cyc + exp_lat(b), id: id_ctr});
    $display("[TB] op%0d MULTU %h x %h issued at cycle %0d", id_ctr, a, b, cyc);
    id_ctr++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_timeout"}, 64'(n >= 100), 64'(0));
  endtask

  task automatic read_chk(input string name, input logic [5:0] f, input logic [W-1:0] exp);
    Signal = f;
    #1;
    check(name, {32'b0, dataOut}, {32'b0, exp});
    Signal = F_MFLO;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    Signal = F_MFHI;
    dataA  = '0;
    dataB  = '0;
    #1 reset = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    read_chk("reset_mfhi", F_MFHI, 32'h0);
    read_chk("reset_mflo", F_MFLO, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First edge after release accepts a multiply.
    do_mult(32'd3, 32'd5, 32'h0000000F, 1'b1);
    check("run_busy", 64'(busy), 64'(1));
    read_chk("run_mflo_prev", F_MFLO, 32'h0);
    wait_idle("mul3x5");
    read_chk("mul3x5_lo", F_MFLO, 32'h0000000F);
    read_chk("mul3x5_hi", F_MFHI, 32'h00000000);
    read_chk("other_funct_zero", F_ADD, 32'h0);

    // Start with a non-MULTU code is ignored.
    Signal = F_MFHI;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    Signal = F_MFLO;
    check("ignored_start_busy", 64'(busy), 64'(0));

    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    idle_cycles(1);
    read_chk("max_run_lo_prev", F_MFLO, 32'h0000000F);
    read_chk("max_run_hi_prev", F_MFHI, 32'h00000000);
    wait_idle("mulmax");
    read_chk("mulmax_hi", F_MFHI, 32'hFFFFFFFE);
    read_chk("mulmax_lo", F_MFLO, 32'h00000001);

    // A second start while running must be dropped.
    do_mult(32'd3, 32'd5, 32'h0000000F, 1'b1);
    idle_cycles(INJ - 1);
    dataA  = 32'd7;
    dataB  = 32'd9;
    Signal = F_MULTU;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    Signal = F_MFLO;
    wait_idle("start_in_run");
    idle_cycles(40);
    check("start_in_run_busy", 64'(busy), 64'(0));
    read_chk("start_in_run_lo", F_MFLO, 32'h0000000F);
    read_chk("start_in_run_hi", F_MFHI, 32'h00000000);

    // Asynchronous reset mid-multiply aborts it.
    do_mult(32'h00010000, 32'h00010000, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    read_chk("abort_mfhi", F_MFHI, 32'h0);
    read_chk("abort_mflo", F_MFLO, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cycles(40);
    check("abort_no_restart", 64'(busy), 64'(0));
    do_mult(32'd2, 32'd2, 32'h00000004, 1'b1);
    wait_idle("mul2x2");
    read_chk("mul2x2_lo", F_MFLO, 32'h00000004);

    do_mult(32'd7, 32'd1, 32'h00000007, 1'b1);
    wait_idle("mul7x1");
    read_chk("mul7x1_lo", F_MFLO, 32'h00000007);
    do_mult(32'd9, 32'd0, 32'h00000000, 1'b1);
    wait_idle("mul9x0");
    read_chk("mul9x0_lo", F_MFLO, 32'h00000000);
    read_chk("mul9x0_hi", F_MFHI, 32'h00000000);

    do_mult(32'h80000000, 32'd2, 32'h00000000, 1'b1);
    wait_idle("carry_hi");
    read_chk("carry_hi_hi", F_MFHI, 32'h00000001);
    do_mult(32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFF0, 1'b1);
    wait_idle("mulx16");
    read_chk("mulx16_hi", F_MFHI, 32'h0000000F);

    idle_cycles(5);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
